conv_pool_seq: RTL

Frame sequencer for the 2x2 max-pool stage. Generates the sample index `cnt` and the qualified `in_vld` strobe that drive the pool block, counting accepted convolution results from 0 to 67 per frame. Signals when each pooled row (three 8-bit results) is final, and when the frame ends. Sits between the convolution engine output and the pool stage, under the top-level calc controller.

---
 rtl/conv_pool_seq.sv | 112 +++++++++++
 1 files changed

// File: rtl/conv_pool_seq.sv
`default_nettype none
// ============================================================================
// conv_pool_seq : sample-index sequencer for the 2x2 max-pool stage.
// Optional idle watchdog: define CONV_POOL_SEQ_TIMEOUT_EN.
// Revision 1.0 - initial release
// ============================================================================
module conv_pool_seq #(
   parameter int FRAME_LEN   = 68,
   parameter int ROW_END0    = 34,
   parameter int ROW_STRIDE  = 16,
   parameter int TIMEOUT_CYC = 255,
   localparam int CW         = $clog2(FRAME_LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          abort,
   input  logic          conv_vld,
   output logic [CW-1:0] cnt,
   output logic          in_vld,
   output logic          busy,
   output logic          row_vld,
   output logic [1:0]    row_idx,
   output logic          done,
   output logic          err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

   state_t       state, state_nxt;
   logic         tmo;
   logic         row_hit;
   logic [1:0]   row_num;

   // abort wins over acceptance, so the pool never sees a sample in that cycle
   assign in_vld = conv_vld & (state == RUN) & ~abort;
   assign busy   = (state == RUN);
   assign done   = (state == DONE);

`ifdef CONV_POOL_SEQ_TIMEOUT_EN
   logic [7:0] wd;
   logic       err_q;

   assign tmo = (state == RUN) & ~conv_vld & ~abort & (wd == 8'(TIMEOUT_CYC - 1));
   assign err = err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd    <= '0;
         err_q <= 1'b0;
      end else begin
         err_q <= tmo;
         if (state != RUN || in_vld || abort || tmo)
            wd <= '0;
         else if (!conv_vld)
            wd <= wd + 8'd1;
      end
   end
`else
   assign tmo = 1'b0;
   assign err = 1'b0;
`endif

   always_comb begin
      row_hit = 1'b0;
      row_num = 2'd0;
      for (int i = 0; i < 3; i++) begin
         if (cnt == CW'(ROW_END0 + ROW_STRIDE * i)) begin
            row_hit = 1'b1;
            row_num = 2'(i);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (in_vld && cnt == LAST) state_nxt = DONE;
         DONE:    state_nxt = start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
      if (abort || tmo)
         state_nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         row_vld <= 1'b0;
         row_idx <= 2'd0;
      end else begin
         state   <= state_nxt;
         row_vld <= in_vld & row_hit;
         if (in_vld && row_hit)
            row_idx <= row_num;
         if (abort || tmo || state != RUN)
            cnt <= '0;
         else if (in_vld)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
      end
   end

endmodule
`default_nettype wire
